// File: rtl/up_dacobuf_mc.sv
`default_nettype none
// ============================================================================
// Module   : up_dacobuf_mc
// Brief    : Multi-channel waveform playback buffer with uP register/memory port
// Revision : 1.0 - initial release
// ============================================================================
module up_dacobuf_mc #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DACBUF_SIZE   = 8,
  parameter int DACDAT_WIDTH  = 14,
  parameter int NUM_CH        = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           up_wreq,
  input  logic [ADDRESS_WIDTH-1:0]       up_waddr,
  input  logic [31:0]                    up_wdata,
  output logic                           up_wack,
  input  logic                           up_rreq,
  input  logic [ADDRESS_WIDTH-1:0]       up_raddr,
  output logic [31:0]                    up_rdata,
  output logic                           up_rack,
  input  logic                           dac_trig_i,
  output logic [NUM_CH*DACDAT_WIDTH-1:0] dac_odat_o,
  output logic                           dac_valid_o,
  output logic                           dac_busy_o
);

  localparam int c_DEPTH = 2 ** DACBUF_SIZE;
  localparam int c_CHW   = ADDRESS_WIDTH - 1 - DACBUF_SIZE;
  localparam int c_CHI   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] c_A_CTRL   = ADDRESS_WIDTH'(0);
  localparam logic [ADDRESS_WIDTH-1:0] c_A_DIV    = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH-1:0] c_A_LEN    = ADDRESS_WIDTH'(2);
  localparam logic [ADDRESS_WIDTH-1:0] c_A_LOOPS  = ADDRESS_WIDTH'(3);
  localparam logic [ADDRESS_WIDTH-1:0] c_A_STATUS = ADDRESS_WIDTH'(4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state, w_state_n;

  logic [DACDAT_WIDTH-1:0] r_mem [NUM_CH][c_DEPTH];

  logic                    r_wflag, r_rflag;
  logic                    w_wacc, w_racc, w_wreg, w_ctrl_wr, w_wmem_ok;
  logic                    w_start, w_stop, w_go, w_enter, w_issue, w_wrap, w_trig_edge;
  logic [c_CHW-1:0]        w_wch, w_rch;
  logic [31:0]             w_rval;
  logic [2:0]              r_trig;
  logic                    r_trigmode, r_cont, r_tm_a, r_cont_a, r_done, r_rd_v;
  logic [15:0]             r_div, r_div_a, r_cnt, r_loops, r_loops_a, r_loop_cnt, r_burst;
  logic [DACBUF_SIZE-1:0]  r_len, r_len_a, r_ptr;
  logic [NUM_CH*DACDAT_WIDTH-1:0] w_pb_flat;
  logic                    w_unused;

  assign w_unused  = &{1'b0, up_wdata[31:16]};

  // The accept flag is simply the registered request: set by an accepted
  // request, cleared once the request is seen low.
  assign w_wacc    = up_wreq & ~r_wflag;
  assign w_racc    = up_rreq & ~r_rflag;
  assign w_wch     = up_waddr[ADDRESS_WIDTH-2:DACBUF_SIZE];
  assign w_rch     = up_raddr[ADDRESS_WIDTH-2:DACBUF_SIZE];
  assign w_wmem_ok = up_waddr[ADDRESS_WIDTH-1] && (int'(w_wch) < NUM_CH);
  assign w_wreg    = w_wacc && !up_waddr[ADDRESS_WIDTH-1];
  assign w_ctrl_wr = w_wreg && (up_waddr == c_A_CTRL);
  assign w_start   = w_ctrl_wr && up_wdata[0];
  assign w_stop    = w_ctrl_wr && up_wdata[1];
  assign w_go      = (r_state == S_IDLE) && w_start && !w_stop;
  assign w_trig_edge = r_trig[1] & ~r_trig[2];
  assign w_enter   = (w_state_n == S_RUN) && (r_state != S_RUN);
  assign dac_busy_o = (r_state == S_ARMED) || (r_state == S_RUN);

  always_comb begin
    w_rval = '0;
    if (up_raddr[ADDRESS_WIDTH-1]) begin
      if (int'(w_rch) < NUM_CH)
        w_rval = 32'(r_mem[w_rch[c_CHI-1:0]][up_raddr[DACBUF_SIZE-1:0]]);
    end else begin
      case (up_raddr)
        c_A_CTRL:   w_rval = {28'd0, r_cont, r_trigmode, 2'b00};
        c_A_DIV:    w_rval = 32'(r_div);
        c_A_LEN:    w_rval = 32'(r_len);
        c_A_LOOPS:  w_rval = 32'(r_loops);
        c_A_STATUS: w_rval = {r_loop_cnt, 13'd0, (r_state == S_ARMED), r_done, dac_busy_o};
        default:    w_rval = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wflag  <= 1'b0;
      r_rflag  <= 1'b0;
      up_wack  <= 1'b0;
      up_rack  <= 1'b0;
      up_rdata <= '0;
    end else begin
      r_wflag <= up_wreq;
      r_rflag <= up_rreq;
      up_wack <= w_wacc;
      up_rack <= w_racc;
      if (w_racc) up_rdata <= w_rval;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_issue   = 1'b0;
    w_wrap    = 1'b0;
    case (r_state)
      S_IDLE:  if (w_go) w_state_n = up_wdata[2] ? S_ARMED : S_RUN;
      S_ARMED: if (w_trig_edge) w_state_n = S_RUN;
      S_RUN: begin
        if (r_cnt == '0) begin
          w_issue = 1'b1;
          if (r_ptr == r_len_a) begin
            w_wrap = 1'b1;
            if (!r_cont_a && (r_burst == r_loops_a))
              w_state_n = r_tm_a ? S_ARMED : S_DONE;
          end
        end
      end
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
    if (w_stop) begin
      w_state_n = S_IDLE;
      w_issue   = 1'b0;
      w_wrap    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_trig      <= '0;
      r_trigmode  <= 1'b0;
      r_cont      <= 1'b0;
      r_div       <= '0;
      r_len       <= '0;
      r_loops     <= '0;
      r_div_a     <= '0;
      r_len_a     <= '0;
      r_loops_a   <= '0;
      r_tm_a      <= 1'b0;
      r_cont_a    <= 1'b0;
      r_done      <= 1'b0;
      r_loop_cnt  <= '0;
      r_burst     <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_rd_v      <= 1'b0;
      dac_valid_o <= 1'b0;
      dac_odat_o  <= '0;
    end else begin
      r_state <= w_state_n;
      r_trig  <= {r_trig[1:0], dac_trig_i};
      if (w_ctrl_wr) begin
        r_trigmode <= up_wdata[2];
        r_cont     <= up_wdata[3];
      end
      if (w_wreg && (up_waddr == c_A_DIV))   r_div   <= up_wdata[15:0];
      if (w_wreg && (up_waddr == c_A_LEN))   r_len   <= up_wdata[DACBUF_SIZE-1:0];
      if (w_wreg && (up_waddr == c_A_LOOPS)) r_loops <= up_wdata[15:0];
      // Playback works from a snapshot so software may reprogram while busy.
      if (w_go) begin
        r_div_a    <= r_div;
        r_len_a    <= r_len;
        r_loops_a  <= r_loops;
        r_tm_a     <= up_wdata[2];
        r_cont_a   <= up_wdata[3];
        r_done     <= 1'b0;
        r_loop_cnt <= '0;
      end
      if (r_state == S_DONE) r_done <= 1'b1;
      if (w_enter) begin
        r_ptr   <= '0;
        r_cnt   <= '0;
        r_burst <= '0;
      end else if (w_issue) begin
        r_cnt <= r_div_a;
        r_ptr <= w_wrap ? '0 : r_ptr + 1'b1;
        if (w_wrap) begin
          r_loop_cnt <= r_loop_cnt + 1'b1;
          r_burst    <= r_burst + 1'b1;
        end
      end else if ((r_state == S_RUN) && !w_stop) begin
        r_cnt <= r_cnt - 1'b1;
      end
      r_rd_v      <= w_issue;
      dac_valid_o <= r_rd_v && !w_stop;
      if (r_rd_v && !w_stop) dac_odat_o <= w_pb_flat;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wacc && w_wmem_ok)
      r_mem[w_wch[c_CHI-1:0]][up_waddr[DACBUF_SIZE-1:0]] <= up_wdata[DACDAT_WIDTH-1:0];
  end

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [DACDAT_WIDTH-1:0] r_pb;
      always_ff @(posedge clk) begin
        if (w_issue) r_pb <= r_mem[c][r_ptr];
      end
      assign w_pb_flat[c*DACDAT_WIDTH +: DACDAT_WIDTH] = r_pb;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_up_dacobuf_mc.sv
`default_nettype none
// Testbench for up_dacobuf_mc: directed sequence with randomized playback runs
// checked against a table/index model of the sample stream.
module tb_up_dacobuf_mc;
  localparam int AW  = 12;
  localparam int DW  = 14;
  localparam int NCH = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            up_wreq = 1'b0;
  logic [AW-1:0]   up_waddr = '0;
  logic [31:0]     up_wdata = '0;
  logic            up_wack;
  logic            up_rreq = 1'b0;
  logic [AW-1:0]   up_raddr = '0;
  logic [31:0]     up_rdata;
  logic            up_rack;
  logic            dac_trig_i = 1'b0;
  logic [NCH*DW-1:0] dac_odat_o;
  logic            dac_valid_o;
  logic            dac_busy_o;

  up_dacobuf_mc #(.ADDRESS_WIDTH(AW), .DACBUF_SIZE(8), .DACDAT_WIDTH(DW), .NUM_CH(NCH)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack),
    .dac_trig_i(dac_trig_i), .dac_odat_o(dac_odat_o), .dac_valid_o(dac_valid_o),
    .dac_busy_o(dac_busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int              n_assert = 0;
  int              n_fail = 0;
  logic            busy_at_ack = 1'b0;
  logic [DW-1:0]   mm [NCH][256];
  int              q_cyc[$];
  logic [NCH*DW-1:0] q_dat[$];

  always @(negedge clk) begin
    if (rst_n && dac_valid_o) begin
      q_cyc.push_back(cyc);
      q_dat.push_back(dac_odat_o);
    end
  end

  initial begin
    #(10_000_000);
    $display("FAIL watchdog: observed no end of test, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input int hold, output int t_ack);
    int acks;
    bit got;
    acks = 0;
    got = 1'b0;
    t_ack = -1;
    @(negedge clk);
    up_wreq = 1'b1; up_waddr = a; up_wdata = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (up_wack) begin
        got = 1'b1; acks++; t_ack = cyc; busy_at_ack = dac_busy_o;
      end
    end
    repeat (hold) begin @(negedge clk); if (up_wack) acks++; end
    up_wreq = 1'b0;
    repeat (2) begin @(negedge clk); if (up_wack) acks++; end
    check("wack_count", acks, 1);
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [31:0] d);
    int acks;
    bit got;
    acks = 0;
    got = 1'b0;
    d = 'x;
    @(negedge clk);
    up_rreq = 1'b1; up_raddr = a;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (up_rack) begin got = 1'b1; acks++; d = up_rdata; end
    end
    up_rreq = 1'b0;
    repeat (3) begin @(negedge clk); if (up_rack) acks++; end
    check("rack_count", acks, 1);
  endtask

  task automatic q_clear();
    q_cyc.delete();
    q_dat.delete();
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && dac_busy_o; i++) @(negedge clk);
    check("idle_timeout", dac_busy_o, 0);
    repeat (5) @(negedge clk);
  endtask

  // Expected stream: k-th strobe carries table index k mod (len+1) and
  // appears 2 cycles after the START ack plus k sample periods.
  task automatic check_stream(input string tag, input int n_exp, input int len, input int div, input int t0);
    logic [NCH*DW-1:0] e;
    int idx;
    check({tag, "_count"}, q_dat.size(), n_exp);
    for (int k = 0; k < q_dat.size(); k++) begin
      idx = k % (len + 1);
      e = {mm[1][idx], mm[0][idx]};
      check({tag, "_data"}, q_dat[k], e);
      check({tag, "_cycle"}, q_cyc[k], t0 + 2 + k * (div + 1));
    end
  endtask

  task automatic pulse_trig();
    @(negedge clk); dac_trig_i = 1'b1;
    repeat (3) @(negedge clk);
    dac_trig_i = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [NCH*DW-1:0] e;
    int ta, ts, tx;

    repeat (3) @(negedge clk);
    check("rst_odat", 32'(dac_odat_o), 0);
    check("rst_valid", dac_valid_o, 0);
    check("rst_busy", dac_busy_o, 0);
    check("rst_wack", up_wack, 0);
    check("rst_rack", up_rack, 0);
    check("rst_rdata", up_rdata, 0);
    rst_n = 1'b1;

    wr(12'h001, 32'd30, 2, ta);
    rd(12'h001, d);
    check("div_readback", d, 30);

    for (int i = 0; i < 256; i++) begin
      mm[0][i] = DW'(i);
      mm[1][i] = DW'(16383 - i);
      wr(AW'(12'h800 + i), 32'(mm[0][i]), 0, tx);
      wr(AW'(12'h900 + i), 32'(mm[1][i]), 0, tx);
    end

    // Continuous run, ignored mid-run START, then STOP
    wr(12'h002, 32'd3, 0, tx);
    wr(12'h001, 32'd1, 0, tx);
    q_clear();
    wr(12'h000, 32'h9, 0, ta);
    repeat (15) @(negedge clk);
    wr(12'h000, 32'h9, 0, tx);
    repeat (10) @(negedge clk);
    wr(12'h000, 32'h2, 0, ts);
    check("stop_busy", busy_at_ack, 0);
    repeat (10) @(negedge clk);
    check_stream("cont", (ts - ta - 1) / 2, 3, 1, ta);

    // Finite bursts
    wr(12'h002, 32'd7, 0, tx);
    wr(12'h001, 32'd0, 0, tx);
    wr(12'h003, 32'd2, 0, tx);
    q_clear();
    wr(12'h000, 32'h1, 0, ta);
    wait_idle(300);
    check_stream("burst", 24, 7, 0, ta);
    e = {mm[1][7], mm[0][7]};
    check("hold_odat", 32'(dac_odat_o), 32'(e));
    rd(12'h004, d);
    check("status_done", d, 32'h0003_0002);

    // Triggered bursts
    wr(12'h001, 32'd2, 0, tx);
    wr(12'h002, 32'd1, 0, tx);
    wr(12'h003, 32'd0, 0, tx);
    q_clear();
    wr(12'h000, 32'h5, 0, ta);
    repeat (10) @(negedge clk);
    check("armed_nostrobe", q_dat.size(), 0);
    rd(12'h004, d);
    check("status_armed", d, 32'h0000_0005);
    pulse_trig();
    repeat (20) @(negedge clk);
    check("trig1_count", q_dat.size(), 2);
    for (int k = 0; k < 2 && k < q_dat.size(); k++)
      check("trig1_data", 32'(q_dat[k]), 32'({mm[1][k], mm[0][k]}));
    rd(12'h004, d);
    check("status_rearm", d, 32'h0001_0005);
    pulse_trig();
    repeat (20) @(negedge clk);
    check("trig2_count", q_dat.size(), 4);
    for (int k = 2; k < 4 && k < q_dat.size(); k++)
      check("trig2_data", 32'(q_dat[k]), 32'({mm[1][k-2], mm[0][k-2]}));
    wr(12'h000, 32'h2, 0, tx);
    repeat (3) @(negedge clk);
    check("trig_stop_busy", dac_busy_o, 0);

    // Randomized runs with fresh table contents
    for (int it = 0; it < 3; it++) begin
      int len, dv, lp;
      len = $urandom_range(15, 0);
      dv  = $urandom_range(3, 0);
      lp  = $urandom_range(2, 0);
      for (int i = 0; i <= len; i++) begin
        for (int c = 0; c < NCH; c++) begin
          mm[c][i] = DW'($urandom);
          wr(AW'(12'h800 + c * 256 + i), 32'(mm[c][i]), 0, tx);
        end
      end
      wr(12'h001, 32'(dv), 0, tx);
      wr(12'h002, 32'(len), 0, tx);
      wr(12'h003, 32'(lp), 0, tx);
      q_clear();
      wr(12'h000, 32'h1, 0, ta);
      wait_idle(400);
      check_stream("rand", (len + 1) * (lp + 1), len, dv, ta);
      rd(12'h004, d);
      check("rand_status", d, {16'(lp + 1), 16'h0002});
      rd(AW'(12'h900 + len), d);
      check("rand_memrd", d, 32'(mm[1][len]));
    end

    // Unmapped accesses
    wr(12'hA00, 32'h1234, 0, tx);
    rd(12'hA00, d);
    check("unmapped_mem_rd", d, 0);
    rd(12'h005, d);
    check("unmapped_reg_rd", d, 0);
    rd(12'h800, d);
    check("mem_rd_ch0", d, 32'(mm[0][0]));

    // Asynchronous reset during playback
    wr(12'h001, 32'd0, 0, tx);
    wr(12'h002, 32'd15, 0, tx);
    q_clear();
    wr(12'h000, 32'h9, 0, ta);
    repeat (5) @(negedge clk);
    check("pre_rst_busy", dac_busy_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_odat", 32'(dac_odat_o), 0);
    check("arst_valid", dac_valid_o, 0);
    check("arst_busy", dac_busy_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", dac_busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/up_dacobuf_mc.md
Name: up_dacobuf_mc

Overview:
Multi-channel arbitrary-waveform playback buffer with a uP register/memory interface. Software loads per-channel sample tables and programs rate, length, loop count and trigger mode, then starts playback. The block streams samples to NUM_CH DAC lanes from a single clock domain, with free-run, triggered-burst and continuous modes. It is the generalised successor of the single-channel DAC output buffer and sits between the uP bus and the DAC front-end.

Parameters:
ADDRESS_WIDTH, 12, uP address width; bit ADDRESS_WIDTH-1 set selects sample memory.
DACBUF_SIZE, 8, log2 of samples per channel (depth 256).
DACDAT_WIDTH, 14, sample width; taken from up_wdata[DACDAT_WIDTH-1:0].
NUM_CH, 2, channel count; NUM_CH*2^DACBUF_SIZE must not exceed 2^(ADDRESS_WIDTH-1).

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
up_wreq  in  1  write request, held until up_wack
up_waddr  in  ADDRESS_WIDTH  write address
up_wdata  in  32  write data
up_wack  out  1  write acknowledge, 1-cycle pulse
up_rreq  in  1  read request, held until up_rack
up_raddr  in  ADDRESS_WIDTH  read address
up_rdata  out  32  read data, valid with up_rack
up_rack  out  1  read acknowledge, 1-cycle pulse
dac_trig_i  in  1  asynchronous external trigger
dac_odat_o  out  NUM_CH*DACDAT_WIDTH  samples, ch0 in LSBs
dac_valid_o  out  1  1-cycle strobe per new sample set
dac_busy_o  out  1  high in ARMED or RUN

Behaviour:
- Reset: all outputs 0; registers 0; state IDLE. Memory contents undefined.
- Register map: 0x000 CTRL (W: bit0 START, bit1 STOP, self-clearing; bit2 TRIGMODE, bit3 CONT; both retained). 0x001 DIV (16 bits; sample period = DIV+1 clk). 0x002 LEN (DACBUF_SIZE bits; samples = LEN+1). 0x003 LOOPS (16 bits; bursts = LOOPS+1). 0x004 STATUS (RO: bit0 busy, bit1 done sticky, bit2 armed, bits[31:16] loops completed). Read of 0x000-0x003 returns stored value.
- Memory: address 0x800 + ch*2^DACBUF_SIZE + idx. ch >= NUM_CH: write acked and dropped, read returns 0. Memory is readable.
- Handshake: request accepted when req=1 and the port's accept flag is clear. Ack is registered one cycle after accept, 1 cycle wide. The flag is set on accept and cleared when req is sampled low, so a req still high in the ack cycle is not re-accepted. Unmapped addresses are acked; writes have no effect; reads return 0. Write and read ports are independent; simultaneous use is allowed.
- dac_trig_i: 2-FF synchronised; the rising edge is used.
- FSM:
  - IDLE: on START, TRIGMODE=0 → RUN; TRIGMODE=1 → ARMED. START clears done.
  - ARMED: on trigger edge → RUN.
  - RUN: sample pointer starts at 0. A sample set is emitted every DIV+1 cycles. The first set appears on dac_odat_o with dac_valid_o exactly 2 cycles after RUN entry (one cycle for memory read). The pointer wraps from LEN to 0. At each wrap, the loop counter increments.
    - CONT=1: run indefinitely.
    - CONT=0, wrap reaching LOOPS+1 bursts: TRIGMODE=0 → DONE; TRIGMODE=1 → ARMED for the next trigger. Loops are reset only by START.
  - DONE: set sticky done, then → IDLE next cycle.
  - STOP in any state → IDLE immediately; pending output not emitted.
- dac_odat_o holds the last emitted set outside RUN; cleared only by reset.
- DIV=0: a new set every cycle.
- START while busy is ignored. Writes to DIV, LEN or LOOPS while busy take effect at the next START.
- Memory writes during RUN are permitted. Same-cycle write and playback read of one entry returns the old data.
- Trigger edge while RUN is ignored.
- rst_n asserted mid-run: immediate IDLE, outputs 0.

Test Plan:
- Reset, then write 0x001=30, read back 0x001 → up_rdata=30 with a single up_rack pulse; wreq held 2 cycles after ack → exactly one up_wack.
- Load ch0[i]=i, ch1[i]=0x3FFF-i for i=0..255; LEN=3, DIV=1, CONT=1, START → dac_valid_o every 2 cycles. Sequence ch0 0,1,2,3,0,…; ch1 0x3FFF,0x3FFE,…; first valid 2 cycles after START ack.
- LEN=7, DIV=0, LOOPS=2, CONT=0, TRIGMODE=0 → exactly 24 valid strobes, then busy=0, STATUS done=1, loops completed=3; output holds value of idx 7.
- TRIGMODE=1, LOOPS=0, LEN=1: START → armed=1 with no strobes; trigger pulse → 2 strobes, back to ARMED; second trigger → 2 more.
- CONT=1 run, write STOP → dac_busy_o=0 the next cycle, no further strobes; START mid-run ignored (pointer sequence unbroken).
- Write and read at 0x800 + NUM_CH*256 → acked; read returns 0. Assert rst_n mid-run → all outputs 0 asynchronously.
